// File: rtl/blockram_sdp_pipe_pkg.sv
// Shared constants and the byte-lane merge helper
// for the simple-dual-port block RAM and its read pipe.
package blockram_sdp_pipe_pkg;

  localparam string COLL_READ_FIRST  = "READ_FIRST";
  localparam string COLL_WRITE_FIRST = "WRITE_FIRST";

  localparam int LAT_LOW  = 1;
  localparam int LAT_HIGH = 2;

  // Upper bounds for the merge helper; callers pad
  // their words up to these widths.
  localparam int MAX_DW  = 512;
  localparam int MAX_COL = 64;

  // Lanes with lane_en set take new_w, the rest old_w.
  function automatic logic [MAX_DW-1:0] merge(
    input logic [MAX_DW-1:0]  old_w,
    input logic [MAX_DW-1:0]  new_w,
    input logic [MAX_COL-1:0] lane_en,
    input int                 nb_col,
    input int                 col_w
  );
    logic [MAX_DW-1:0] r;
    r = old_w;
    for (int i = 0; i < MAX_DW; i++) begin
      if (i < nb_col * col_w) begin
        if (lane_en[i / col_w]) begin
          r[i] = new_w[i];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/blockram_rd_pipe.sv
// Stage-2 read register: valid/data pipe with async reset.
// Ports: CLK, RESET, i_v/i_d from stage 1, o_v/o_d to output.
import blockram_sdp_pipe_pkg::*;

module blockram_rd_pipe #(
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          i_v,
  input  logic [DW-1:0] i_d,
  output logic          o_v,
  output logic [DW-1:0] o_d
);

  logic          r_v;
  logic [DW-1:0] r_d;

  // Data only advances behind a valid word so the
  // output holds the last completed read.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_v <= 1'b0;
      r_d <= '0;
    end else begin
      r_v <= i_v;
      if (i_v) begin
        r_d <= i_d;
      end
    end
  end

  assign o_v = r_v;
  assign o_d = r_d;

endmodule

// File: rtl/blockram_sdp_pipe.sv
// Simple-dual-port byte-writable block RAM, 1/2-cycle read.
// Ports: CLK, RESET, wren/bwren/wraddrs/wrdata, rden/rdaddrs,
//        rddata/rdvalid (registered, aligned).
import blockram_sdp_pipe_pkg::*;

module blockram_sdp_pipe #(
  parameter int    ADDRS_WIDTH = 11,
  parameter int    NB_COL      = 4,
  parameter int    COL_WIDTH   = 8,
  parameter int    RD_LATENCY  = 1,
  parameter string COLLISION   = "READ_FIRST",
  parameter string INIT_FILE   = ""
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        wren,
  input  logic [NB_COL-1:0]           bwren,
  input  logic [ADDRS_WIDTH-1:0]      wraddrs,
  input  logic [NB_COL*COL_WIDTH-1:0] wrdata,
  input  logic                        rden,
  input  logic [ADDRS_WIDTH-1:0]      rdaddrs,
  output logic [NB_COL*COL_WIDTH-1:0] rddata,
  output logic                        rdvalid
);

  localparam int DW    = NB_COL * COL_WIDTH;
  localparam int DEPTH = 2 ** ADDRS_WIDTH;
  localparam bit WF    = (COLLISION == COLL_WRITE_FIRST);

  if (RD_LATENCY != LAT_LOW &&
      RD_LATENCY != LAT_HIGH) begin : g_bad_lat
    $error("RD_LATENCY must be 1 or 2");
  end

  if (COLLISION != COLL_READ_FIRST &&
      COLLISION != COLL_WRITE_FIRST) begin : g_bad_coll
    $error("COLLISION must be READ_FIRST or WRITE_FIRST");
  end

  if (DW >= MAX_DW || NB_COL > MAX_COL) begin : g_bad_dw
    $error("data width exceeds merge helper bounds");
  end

  logic [DW-1:0] r_mem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      r_mem[i] = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (wren) begin
      for (int i = 0; i < NB_COL; i++) begin
        if (bwren[i]) begin
          r_mem[wraddrs][i*COL_WIDTH +: COL_WIDTH]
            <= wrdata[i*COL_WIDTH +: COL_WIDTH];
        end
      end
    end
  end

  logic [DW-1:0]      w_old;
  logic               w_hit;
  logic [NB_COL-1:0]  w_fwd_en;
  logic [MAX_DW-1:0]  w_old_x;
  logic [MAX_DW-1:0]  w_new_x;
  logic [MAX_COL-1:0] w_en_x;
  logic [MAX_DW-1:0]  w_mrg_x;
  logic               w_mrg_unused;

  assign w_old = r_mem[rdaddrs];
  assign w_hit = wren && (rdaddrs == wraddrs);

  // Only WRITE_FIRST forwards same-edge write lanes.
  assign w_fwd_en = (WF && w_hit) ? bwren : '0;

  always_comb begin
    w_old_x = '0;
    w_new_x = '0;
    w_en_x  = '0;
    w_old_x[DW-1:0]     = w_old;
    w_new_x[DW-1:0]     = wrdata;
    w_en_x[NB_COL-1:0]  = w_fwd_en;
  end

  assign w_mrg_x = merge(w_old_x, w_new_x, w_en_x,
                         NB_COL, COL_WIDTH);
  assign w_mrg_unused = ^w_mrg_x[MAX_DW-1:DW];

  logic          r_s1_v;
  logic [DW-1:0] r_s1_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_s1_v <= 1'b0;
      r_s1_d <= '0;
    end else begin
      r_s1_v <= rden;
      if (rden) begin
        r_s1_d <= w_mrg_x[DW-1:0];
      end
    end
  end

  if (RD_LATENCY == LAT_HIGH) begin : g_lat2
    blockram_rd_pipe #(
      .DW (DW)
    ) u_rd_pipe (
      .CLK   (CLK),
      .RESET (RESET),
      .i_v   (r_s1_v),
      .i_d   (r_s1_d),
      .o_v   (rdvalid),
      .o_d   (rddata)
    );
  end else begin : g_lat1
    assign rddata  = r_s1_d;
    assign rdvalid = r_s1_v;
  end

endmodule

// File: tb/tb_blockram_sdp_pipe.sv
// Scoreboard bench: A=lat1/RF, B=lat1/WF, C=lat2/RF
// on a shared bus, D=72-bit 16-deep lat1.
module tb_blockram_sdp_pipe;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  logic        wren = 0, rden = 0;
  logic [3:0]  bwren = 0;
  logic [10:0] wraddrs = 0, rdaddrs = 0;
  logic [31:0] wrdata = 0;
  logic [31:0] a_d, b_d, c_d;
  logic        a_v, b_v, c_v;

  logic        d_wren = 0, d_rden = 0;
  logic [7:0]  d_bwren = 0;
  logic [3:0]  d_wa = 0, d_ra = 0;
  logic [71:0] d_wd = 0;
  logic [71:0] d_d;
  logic        d_v;

  blockram_sdp_pipe u_a (
    .CLK(CLK), .RESET(RESET), .wren(wren), .bwren(bwren),
    .wraddrs(wraddrs), .wrdata(wrdata), .rden(rden),
    .rdaddrs(rdaddrs), .rddata(a_d), .rdvalid(a_v));

  blockram_sdp_pipe #(.COLLISION("WRITE_FIRST")) u_b (
    .CLK(CLK), .RESET(RESET), .wren(wren), .bwren(bwren),
    .wraddrs(wraddrs), .wrdata(wrdata), .rden(rden),
    .rdaddrs(rdaddrs), .rddata(b_d), .rdvalid(b_v));

  blockram_sdp_pipe #(.RD_LATENCY(2)) u_c (
    .CLK(CLK), .RESET(RESET), .wren(wren), .bwren(bwren),
    .wraddrs(wraddrs), .wrdata(wrdata), .rden(rden),
    .rdaddrs(rdaddrs), .rddata(c_d), .rdvalid(c_v));

  blockram_sdp_pipe #(
    .ADDRS_WIDTH(4), .NB_COL(8), .COL_WIDTH(9)
  ) u_d (
    .CLK(CLK), .RESET(RESET), .wren(d_wren),
    .bwren(d_bwren), .wraddrs(d_wa), .wrdata(d_wd),
    .rden(d_rden), .rdaddrs(d_ra), .rddata(d_d),
    .rdvalid(d_v));

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [71:0] q_d [4][$];
  int          q_t [4][$];
  logic [71:0] last [4];

  task automatic chk(input string nm, input int id,
                     input logic [71:0] act,
                     input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h need %h",
               nm, id, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [71:0] d,
                      input int due);
    q_d[id].push_back(d);
    q_t[id].push_back(due);
  endtask

  task automatic mon(input int id, input logic v,
                     input logic [71:0] d);
    logic [71:0] e;
    int t;
    if (RESET) begin
      q_d[id].delete();
      q_t[id].delete();
      last[id] = '0;
      chk("rst_valid", id, 72'(v), 72'(0));
      chk("rst_data", id, d, 72'(0));
      return;
    end
    if (v) begin
      if (q_d[id].size() == 0) begin
        chk("unexpected_valid", id, 72'(1), 72'(0));
      end else begin
        e = q_d[id].pop_front();
        t = q_t[id].pop_front();
        chk("rd_data", id, d, e);
        chk("rd_cycle", id, 72'(cyc), 72'(t));
        last[id] = e;
      end
    end else begin
      chk("hold_data", id, d, last[id]);
    end
  endtask

  always @(negedge CLK) begin
    mon(0, a_v, 72'(a_d));
    mon(1, b_v, 72'(b_d));
    mon(2, c_v, 72'(c_d));
    mon(3, d_v, d_d);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic op(input logic we, input logic [3:0] be,
                    input logic [10:0] wa,
                    input logic [31:0] wd,
                    input logic re, input logic [10:0] ra,
                    input logic [31:0] ea,
                    input logic [31:0] eb,
                    input logic [31:0] ec);
    wren = we; bwren = be; wraddrs = wa; wrdata = wd;
    rden = re; rdaddrs = ra;
    if (re) begin
      push(0, 72'(ea), cyc + 1);
      push(1, 72'(eb), cyc + 1);
      push(2, 72'(ec), cyc + 2);
    end
    step();
    wren = 0; rden = 0; bwren = 0;
  endtask

  task automatic wr(input logic [10:0] a,
                    input logic [31:0] d,
                    input logic [3:0] be);
    op(1, be, a, d, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input logic [10:0] a,
                    input logic [31:0] e);
    op(0, 0, 0, 0, 1, a, e, e, e);
  endtask

  task automatic dop(input logic we, input logic [3:0] wa,
                     input logic [71:0] wd,
                     input logic re, input logic [3:0] ra,
                     input logic [71:0] e);
    d_wren = we; d_bwren = 8'hFF; d_wa = wa; d_wd = wd;
    d_rden = re; d_ra = ra;
    if (re) push(3, e, cyc + 1);
    step();
    d_wren = 0; d_rden = 0; d_bwren = 0;
  endtask

  function automatic logic [71:0] pat(input int a);
    logic [71:0] r;
    for (int l = 0; l < 8; l++) begin
      r[l*9 +: 9] = 9'(a * 8 + l) ^ 9'h1A5;
    end
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) last[i] = '0;
    RESET = 1'b1;
    repeat (3) step();
    RESET = 1'b0;
    repeat (2) step();

    rd(11'd0, 32'h0);
    repeat (3) step();

    wr(11'd5, 32'h11223344, 4'hF);
    wr(11'd5, 32'hAABBCCDD, 4'b0101);
    rd(11'd5, 32'h11BB33DD);
    repeat (2) step();

    wr(11'd7, 32'h01020304, 4'hF);
    op(1, 4'b1100, 11'd7, 32'hFFFFFFFF, 1, 11'd7,
       32'h01020304, 32'hFFFF0304, 32'h01020304);
    rd(11'd7, 32'hFFFF0304);
    repeat (2) step();

    wr(11'd1, 32'd10, 4'hF);
    wr(11'd2, 32'd20, 4'hF);
    wr(11'd3, 32'd30, 4'hF);
    rd(11'd1, 32'd10);
    rd(11'd2, 32'd20);
    rd(11'd3, 32'd30);
    repeat (4) step();

    wr(11'd1, 32'hFFFFFFFF, 4'h0);
    rd(11'd1, 32'd10);
    wr(11'h7FF, 32'h5A5AA5A5, 4'hF);
    rd(11'h7FF, 32'h5A5AA5A5);
    repeat (3) step();

    wr(11'd9, 32'hCAFEF00D, 4'hF);
    rd(11'd9, 32'hCAFEF00D);
    RESET = 1'b1;
    #1;
    chk("async_rst_valid", 0, 72'(a_v), 72'(0));
    chk("async_rst_data", 0, 72'(a_d), 72'(0));
    chk("async_rst_valid", 2, 72'(c_v), 72'(0));
    chk("async_rst_data", 2, 72'(c_d), 72'(0));
    repeat (2) step();
    RESET = 1'b0;
    repeat (3) step();
    rd(11'd9, 32'hCAFEF00D);
    repeat (3) step();

    for (int a = 0; a < 16; a++) begin
      dop(1, 4'(a), pat(a), 0, 0, 0);
    end
    for (int a = 15; a >= 0; a--) begin
      dop(0, 0, 0, 1, 4'(a), pat(a));
    end
    repeat (4) step();

    for (int i = 0; i < 4; i++) begin
      chk("queue_drained", i, 72'(q_d[i].size()), 72'(0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
